// File: rtl/br_update_funnel.sv
// Branch-resolution funnel: gathers per-lane conditional-branch outcomes, flags the oldest
// mispredict for a history-recovery pulse, squashes wrong-path results and queues PHT updates.
module br_update_funnel #(
    parameter int LANE_NUM = 2,
    parameter int HIST_W   = 10,
    parameter int IDX_W    = 12,
    parameter int CNT_W    = 2,
    parameter int DEPTH    = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [LANE_NUM-1:0]        inValid,
    input  logic [IDX_W-1:0]           inPhtIndex [LANE_NUM],
    input  logic [CNT_W-1:0]           inPrevCnt  [LANE_NUM],
    input  logic [HIST_W-1:0]          inHist     [LANE_NUM],
    input  logic [LANE_NUM-1:0]        inPredTaken,
    input  logic [LANE_NUM-1:0]        inExecTaken,
    output logic                       inReady,
    input  logic                       flushDone,
    output logic                       recover,
    output logic [HIST_W-1:0]          recoveredHist,
    output logic                       outValid,
    input  logic                       outReady,
    output logic [IDX_W-1:0]           outPhtIndex,
    output logic [CNT_W-1:0]           outPrevCnt,
    output logic                       outExecTaken,
    output logic                       outMispred,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    typedef enum logic {RUN, SQUASH} state_t;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [CNT_W-1:0] cnt;
        logic             exec;
        logic             mispred;
    } entry_t;

    state_t             state_q, state_d;
    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   head_q, tail_q;
    logic [OCC_W-1:0]   occ_q;
    logic               recover_q;
    logic [HIST_W-1:0]  rec_hist_q;

    logic               accept_run;
    logic               pop;
    logic [LANE_NUM-1:0] keep;
    logic [PTR_W-1:0]   pos [LANE_NUM];
    logic [OCC_W-1:0]   push_cnt;
    logic               mis_found;
    logic [HIST_W-1:0]  mis_hist;
    logic               stop;

    assign inReady    = (OCC_W'(DEPTH) - occ_q) >= OCC_W'(LANE_NUM);
    assign accept_run = inReady && (state_q == RUN);
    assign outValid   = (occ_q != '0);
    assign pop        = outValid && outReady;

    // Lanes are kept in program order up to and including the first mispredict;
    // each kept lane gets a consecutive slot starting at the tail.
    always_comb begin
        keep      = '0;
        push_cnt  = '0;
        stop      = 1'b0;
        mis_found = 1'b0;
        mis_hist  = '0;
        for (int i = 0; i < LANE_NUM; i++) begin
            pos[i] = tail_q + PTR_W'(push_cnt);
            if (accept_run && !stop && inValid[i]) begin
                keep[i]  = 1'b1;
                push_cnt = push_cnt + OCC_W'(1);
                if (inPredTaken[i] != inExecTaken[i]) begin
                    stop      = 1'b1;
                    mis_found = 1'b1;
                    mis_hist  = (inHist[i] << 1) | HIST_W'(inExecTaken[i]);
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (accept_run && mis_found) state_d = SQUASH;
            SQUASH:  if (flushDone) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            head_q     <= '0;
            tail_q     <= '0;
            occ_q      <= '0;
            recover_q  <= 1'b0;
            rec_hist_q <= '0;
        end else begin
            state_q   <= state_d;
            head_q    <= head_q + PTR_W'(pop);
            tail_q    <= tail_q + PTR_W'(push_cnt);
            occ_q     <= occ_q + push_cnt - OCC_W'(pop);
            recover_q <= accept_run && mis_found;
            if (accept_run && mis_found) rec_hist_q <= mis_hist;
        end
    end

    // Storage needs no reset: occupancy alone qualifies the contents.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANE_NUM; i++) begin
            if (keep[i]) begin
                mem[pos[i]] <= '{idx: inPhtIndex[i], cnt: inPrevCnt[i], exec: inExecTaken[i],
                                 mispred: inPredTaken[i] ^ inExecTaken[i]};
            end
        end
    end

    assign outPhtIndex   = mem[head_q].idx;
    assign outPrevCnt    = mem[head_q].cnt;
    assign outExecTaken  = mem[head_q].exec;
    assign outMispred    = mem[head_q].mispred;
    assign occupancy     = occ_q;
    assign recover       = recover_q;
    assign recoveredHist = rec_hist_q;

endmodule

// File: tb/tb_br_update_funnel.sv
// Bench for br_update_funnel: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_br_update_funnel;

    localparam int LANE_NUM = 2;
    localparam int HIST_W   = 10;
    localparam int IDX_W    = 12;
    localparam int CNT_W    = 2;
    localparam int DEPTH    = 8;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [LANE_NUM-1:0] inValid;
    logic [IDX_W-1:0]    inPhtIndex [LANE_NUM];
    logic [CNT_W-1:0]    inPrevCnt  [LANE_NUM];
    logic [HIST_W-1:0]   inHist     [LANE_NUM];
    logic [LANE_NUM-1:0] inPredTaken;
    logic [LANE_NUM-1:0] inExecTaken;
    logic                inReady;
    logic                flushDone;
    logic                recover;
    logic [HIST_W-1:0]   recoveredHist;
    logic                outValid;
    logic                outReady;
    logic [IDX_W-1:0]    outPhtIndex;
    logic [CNT_W-1:0]    outPrevCnt;
    logic                outExecTaken;
    logic                outMispred;
    logic [$clog2(DEPTH):0] occupancy;

    int n_chk  = 0;
    int n_fail = 0;

    br_update_funnel #(
        .LANE_NUM(LANE_NUM), .HIST_W(HIST_W), .IDX_W(IDX_W), .CNT_W(CNT_W), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .inValid(inValid), .inPhtIndex(inPhtIndex), .inPrevCnt(inPrevCnt), .inHist(inHist),
        .inPredTaken(inPredTaken), .inExecTaken(inExecTaken), .inReady(inReady),
        .flushDone(flushDone), .recover(recover), .recoveredHist(recoveredHist),
        .outValid(outValid), .outReady(outReady), .outPhtIndex(outPhtIndex),
        .outPrevCnt(outPrevCnt), .outExecTaken(outExecTaken), .outMispred(outMispred),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of what the predictor should see, in order.
    typedef struct {
        int idx;
        int cnt;
        int ex;
        int mis;
    } ent_t;

    ent_t m_q[$];
    bit   m_squash;
    bit   m_rec;
    int   m_hist;
    bit   m_ready, m_pop, m_hit;
    ent_t m_e;

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_squash = 0;
            m_rec    = 0;
            m_hist   = 0;
        end else begin
            m_ready = (DEPTH - m_q.size()) >= LANE_NUM;
            m_pop   = (m_q.size() != 0) && outReady;
            m_hit   = 0;
            m_rec   = 0;
            if (m_pop) void'(m_q.pop_front());
            if (m_squash) begin
                if (flushDone) m_squash = 0;
            end else if (m_ready) begin
                for (int l = 0; l < LANE_NUM; l++) begin
                    if (!m_hit && inValid[l]) begin
                        m_e.idx = int'(inPhtIndex[l]);
                        m_e.cnt = int'(inPrevCnt[l]);
                        m_e.ex  = int'(inExecTaken[l]);
                        m_e.mis = (inPredTaken[l] != inExecTaken[l]) ? 1 : 0;
                        m_q.push_back(m_e);
                        if (m_e.mis != 0) begin
                            m_hit  = 1;
                            m_rec  = 1;
                            m_hist = ((int'(inHist[l]) * 2) + m_e.ex) % (1 << HIST_W);
                        end
                    end
                end
                if (m_hit) m_squash = 1;
            end
        end
        #1;
        chk("model_occupancy", 32'(occupancy), 32'(m_q.size()));
        chk("model_in_ready", 32'(inReady), 32'((DEPTH - m_q.size()) >= LANE_NUM));
        chk("model_out_valid", 32'(outValid), 32'(m_q.size() != 0));
        chk("model_recover", 32'(recover), 32'(m_rec));
        if (m_q.size() != 0) begin
            chk("model_out_idx", 32'(outPhtIndex), 32'(m_q[0].idx));
            chk("model_out_cnt", 32'(outPrevCnt), 32'(m_q[0].cnt));
            chk("model_out_exec", 32'(outExecTaken), 32'(m_q[0].ex));
            chk("model_out_mispred", 32'(outMispred), 32'(m_q[0].mis));
        end
        if (m_rec) chk("model_rec_hist", 32'(recoveredHist), 32'(m_hist));
    end

    task automatic set_lane(input int l, input logic [IDX_W-1:0] idx, input logic [CNT_W-1:0] cnt,
                            input logic [HIST_W-1:0] h, input logic p, input logic e);
        inValid[l]     = 1'b1;
        inPhtIndex[l]  = idx;
        inPrevCnt[l]   = cnt;
        inHist[l]      = h;
        inPredTaken[l] = p;
        inExecTaken[l] = e;
    endtask

    task automatic clear_lanes();
        for (int l = 0; l < LANE_NUM; l++) begin
            inValid[l]     = 1'b0;
            inPhtIndex[l]  = '0;
            inPrevCnt[l]   = '0;
            inHist[l]      = '0;
            inPredTaken[l] = 1'b0;
            inExecTaken[l] = 1'b0;
        end
    endtask

    initial begin
        clear_lanes();
        flushDone = 1'b0;
        outReady  = 1'b0;
        rst       = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_occ", 32'(occupancy), 0);
        chk("reset_valid", 32'(outValid), 0);
        chk("reset_ready", 32'(inReady), 1);
        chk("reset_recover", 32'(recover), 0);
        chk("reset_hist", 32'(recoveredHist), 0);
        rst = 1'b0;

        // single correct branch flows straight through
        outReady = 1'b1;
        set_lane(0, 12'h005, 2'd2, 10'h000, 1'b1, 1'b1);
        @(negedge clk);
        chk("t1_valid", 32'(outValid), 1);
        chk("t1_idx", 32'(outPhtIndex), 32'h005);
        chk("t1_mis", 32'(outMispred), 0);
        chk("t1_recover", 32'(recover), 0);
        clear_lanes();
        @(negedge clk);
        chk("t1_occ_after_pop", 32'(occupancy), 0);

        // lane1 mispredicts: both kept, history recovered from lane1
        outReady = 1'b0;
        set_lane(0, 12'h010, 2'd1, 10'h000, 1'b0, 1'b0);
        set_lane(1, 12'h011, 2'd3, 10'h3FF, 1'b1, 1'b0);
        @(negedge clk);
        chk("t2_recover", 32'(recover), 1);
        chk("t2_hist", 32'(recoveredHist), 32'h3FE);
        chk("t2_occ", 32'(occupancy), 2);
        chk("t2_head_idx", 32'(outPhtIndex), 32'h010);
        clear_lanes();
        outReady = 1'b1;
        @(negedge clk);
        chk("t2_recover_off", 32'(recover), 0);
        chk("t2_second_idx", 32'(outPhtIndex), 32'h011);
        chk("t2_second_mis", 32'(outMispred), 1);
        set_lane(0, 12'h0AA, 2'd0, 10'h000, 1'b0, 1'b0);
        @(negedge clk);
        chk("t2_squash_drop", 32'(occupancy), 0);
        flushDone = 1'b1;
        @(negedge clk);
        chk("t2_flush_cycle_drop", 32'(occupancy), 0);
        flushDone = 1'b0;
        outReady  = 1'b0;
        set_lane(0, 12'h020, 2'd1, 10'h000, 1'b1, 1'b1);
        @(negedge clk);
        chk("t2_after_flush_accept", 32'(occupancy), 1);
        clear_lanes();

        // lane0 mispredicts: lane1 dropped
        set_lane(0, 12'h030, 2'd0, 10'h001, 1'b0, 1'b1);
        set_lane(1, 12'h031, 2'd0, 10'h002, 1'b0, 1'b0);
        @(negedge clk);
        chk("t3_recover", 32'(recover), 1);
        chk("t3_hist", 32'(recoveredHist), 32'h003);
        chk("t3_occ", 32'(occupancy), 2);
        @(negedge clk);
        chk("t3_squash_drop", 32'(occupancy), 2);
        chk("t3_no_second_recover", 32'(recover), 0);
        flushDone = 1'b1;
        @(negedge clk);
        chk("t3_flush_cycle_drop", 32'(occupancy), 2);
        flushDone = 1'b0;
        clear_lanes();
        set_lane(0, 12'h040, 2'd1, 10'h000, 1'b0, 1'b0);
        set_lane(1, 12'h041, 2'd2, 10'h000, 1'b1, 1'b1);
        @(negedge clk);
        chk("t3_accept_after_flush", 32'(occupancy), 4);
        clear_lanes();

        // fill to full with outReady low
        outReady = 1'b1;
        repeat (4) @(negedge clk);
        chk("t4_drained", 32'(occupancy), 0);
        outReady = 1'b0;
        for (int g = 0; g < 4; g++) begin
            set_lane(0, 12'(12'h100 + 2 * g), 2'(g), 10'h000, 1'b1, 1'b1);
            set_lane(1, 12'(12'h101 + 2 * g), 2'(g + 1), 10'h000, 1'b0, 1'b0);
            @(negedge clk);
        end
        chk("t4_full_occ", 32'(occupancy), 8);
        chk("t4_full_ready", 32'(inReady), 0);
        set_lane(0, 12'h1F0, 2'd0, 10'h000, 1'b1, 1'b0);
        set_lane(1, 12'h1F1, 2'd0, 10'h000, 1'b0, 1'b0);
        @(negedge clk);
        chk("t4_ignored_occ", 32'(occupancy), 8);
        chk("t4_ignored_recover", 32'(recover), 0);
        clear_lanes();
        outReady = 1'b1;
        @(negedge clk);
        chk("t4_pop_occ", 32'(occupancy), 7);
        chk("t4_pop_ready", 32'(inReady), 0);
        outReady = 1'b0;
        @(negedge clk);
        chk("t4_hold_ready", 32'(inReady), 0);

        // drain two, push across the pointer wrap, then drain all
        outReady = 1'b1;
        repeat (2) @(negedge clk);
        chk("t5_occ", 32'(occupancy), 5);
        chk("t5_ready", 32'(inReady), 1);
        outReady = 1'b0;
        set_lane(0, 12'h200, 2'd3, 10'h000, 1'b0, 1'b0);
        set_lane(1, 12'h201, 2'd1, 10'h000, 1'b1, 1'b1);
        @(negedge clk);
        chk("t5_wrap_occ", 32'(occupancy), 7);
        clear_lanes();
        outReady = 1'b1;
        repeat (5) @(negedge clk);
        chk("t5_wrap_head_idx", 32'(outPhtIndex), 32'h200);
        chk("t5_wrap_head_cnt", 32'(outPrevCnt), 3);
        repeat (2) @(negedge clk);
        chk("t5_empty", 32'(occupancy), 0);

        // reset while a recover pulse is pending
        outReady = 1'b0;
        set_lane(0, 12'h300, 2'd0, 10'h000, 1'b1, 1'b1);
        set_lane(1, 12'h301, 2'd0, 10'h000, 1'b0, 1'b0);
        @(negedge clk);
        clear_lanes();
        set_lane(0, 12'h302, 2'd1, 10'h155, 1'b1, 1'b0);
        @(negedge clk);
        chk("t6_recover", 32'(recover), 1);
        chk("t6_hist", 32'(recoveredHist), 32'h2AA);
        chk("t6_occ", 32'(occupancy), 3);
        rst = 1'b1;
        #1;
        chk("t6_rst_recover", 32'(recover), 0);
        chk("t6_rst_valid", 32'(outValid), 0);
        chk("t6_rst_occ", 32'(occupancy), 0);
        clear_lanes();
        @(negedge clk);
        rst = 1'b0;
        set_lane(0, 12'h400, 2'd2, 10'h000, 1'b0, 1'b0);
        @(negedge clk);
        chk("t6_run_after_rst", 32'(occupancy), 1);
        clear_lanes();
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
